mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data port onto one shared
//   memory port. One transaction is in flight at a time; the winner's command
//   is latched on the grant edge and the memory port is driven only from those
//   latched registers. Completion (x_resp / x_rdata) is returned
//   combinationally in the cycle the memory answers.
//
//   Optional feature: define MEM_ARB_RR_EN to resolve simultaneous requests
//   round-robin. Without it, data always beats fetch.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (byte enables are DATA_W/8 wide)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_read, i_addr                fetch request (held until i_resp)
//   i_rdata, i_resp               fetch data / one-cycle completion pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_be                 data request (held until d_resp)
//   d_rdata, d_resp               data read data / one-cycle completion pulse
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_be             shared memory command (registered)
//   mem_rdata, mem_resp           memory read data / completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_r;
  logic              rd_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;

  logic d_req_s;
  logic grant_d_s;
  logic grant_i_s;

`ifdef MEM_ARB_RR_EN
  // 1 = data was served last, 0 = fetch was served last.
  logic last_d_r;
`endif

  // Grant decision, only meaningful while IDLE.
  always_comb begin
    d_req_s   = d_read | d_write;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
`ifdef MEM_ARB_RR_EN
      // On a tie, data wins only if fetch was the last one served.
      grant_d_s = d_req_s & (~i_read | ~last_d_r);
`else
      grant_d_s = d_req_s;
`endif
      grant_i_s = i_read & ~grant_d_s;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Arbiter FSM; latches the winning command and drives the memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r <= SERVE_D;
            // Read+write together is a write.
            wr_r    <= d_write;
            rd_r    <= ~d_write;
            addr_r  <= d_addr;
            wdata_r <= d_wdata;
            be_r    <= d_be;
          end else if (grant_i_s) begin
            state_r <= SERVE_I;
            wr_r    <= 1'b0;
            rd_r    <= 1'b1;
            addr_r  <= i_addr;
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= {BE_W{1'b1}};
          end else begin
            state_r <= IDLE;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Requester lines are not watched here: the latched command runs
          // to completion even if the request drops.
          if (mem_resp) begin
            state_r <= IDLE;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-served tracking, updated on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_r <= 1'b0;
    end else if (grant_d_s | grant_i_s) begin
      last_d_r <= grant_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`endif

  // Memory port comes straight from the latched registers.
  always_comb begin
    mem_read  = rd_r;
    mem_write = wr_r;
    mem_addr  = addr_r;
    mem_wdata = wdata_r;
    mem_be    = be_r;
  end

  // Completion routing: memory response is only forwarded to the requester
  // currently being served; a response seen in IDLE goes nowhere.
  always_comb begin
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    i_rdata = {DATA_W{1'b0}};
    d_rdata = {DATA_W{1'b0}};
    if (mem_resp && state_r == SERVE_I) begin
      i_resp  = 1'b1;
      i_rdata = mem_rdata;
    end else if (mem_resp && state_r == SERVE_D) begin
      d_resp  = 1'b1;
      d_rdata = mem_rdata;
    end else begin
      i_resp  = 1'b0;
      d_resp  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed testbench for mem_arbiter. Inputs change 1 time unit after the
//   rising edge and outputs are sampled shortly afterwards, away from the edge.
//   Tie-break expectations follow MEM_ARB_RR_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tie winners for four consecutive grants (1 = data).
  logic [3:0] tie_exp;

  initial begin
`ifdef MEM_ARB_RR_EN
    tie_exp = 4'b0101;  // grant 0..3: D, I, D, I (bit k = grant k)
`else
    tie_exp = 4'b1111;
`endif
    rst = 1'b1; i_read = 1'b0; i_addr = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_be", {60'd0, mem_be}, 64'd0);
    check("rst_resps", {62'd0, i_resp, d_resp}, 64'd0);
    rst = 1'b0;

    // Fetch with 3-cycle memory latency
    i_read = 1'b1; i_addr = 32'h100;
    #1;
    check("f_nocmd_same_cycle", {63'd0, mem_read}, 64'd0);
    tick();
    check("f_c1_mem_read", {63'd0, mem_read}, 64'd1);
    check("f_c1_addr", {32'd0, mem_addr}, 64'h100);
    check("f_c1_be", {60'd0, mem_be}, 64'hF);
    check("f_c1_no_write", {63'd0, mem_write}, 64'd0);
    mem_rdata = 32'h11111111;
    #1;
    check("f_c1_rdata_zero", {32'd0, i_rdata}, 64'd0);
    tick();
    check("f_c2_mem_read", {63'd0, mem_read}, 64'd1);
    check("f_c2_no_resp", {63'd0, i_resp}, 64'd0);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("f_c3_mem_read", {63'd0, mem_read}, 64'd1);
    check("f_c3_i_resp", {63'd0, i_resp}, 64'd1);
    check("f_c3_i_rdata", {32'd0, i_rdata}, 64'hDEADBEEF);
    check("f_c3_d_resp", {63'd0, d_resp}, 64'd0);
    tick();
    i_read = 1'b0; mem_resp = 1'b0;
    #1;
    check("f_done_mem_read", {63'd0, mem_read}, 64'd0);
    check("f_done_i_resp", {63'd0, i_resp}, 64'd0);
    check("f_done_i_rdata", {32'd0, i_rdata}, 64'd0);

    // Data write
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
    tick();
    check("w_mem_write", {63'd0, mem_write}, 64'd1);
    check("w_mem_read", {63'd0, mem_read}, 64'd0);
    check("w_addr", {32'd0, mem_addr}, 64'h200);
    check("w_wdata", {32'd0, mem_wdata}, 64'h12345678);
    check("w_be", {60'd0, mem_be}, 64'h3);
    check("w_i_resp_pre", {63'd0, i_resp}, 64'd0);
    mem_resp = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("w_d_resp", {63'd0, d_resp}, 64'd1);
    check("w_i_resp", {63'd0, i_resp}, 64'd0);
    check("w_i_rdata", {32'd0, i_rdata}, 64'd0);
    tick();
    d_write = 1'b0; mem_resp = 1'b0;
    #1;
    check("w_done_mem_write", {63'd0, mem_write}, 64'd0);
    check("w_done_d_resp", {63'd0, d_resp}, 64'd0);

    // Tie arbitration from a fresh reset, both requesters always asserted
    rst = 1'b1;
    #2;
    rst = 1'b0;
    i_read = 1'b1; i_addr = 32'hA00;
    d_read = 1'b1; d_addr = 32'hB00; d_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("tie_addr", {32'd0, mem_addr}, tie_exp[k] ? 64'hB00 : 64'hA00);
      check("tie_mem_read", {63'd0, mem_read}, 64'd1);
      mem_resp = 1'b1; mem_rdata = 32'h1000 + k;
      #1;
      check("tie_d_resp", {63'd0, d_resp}, {63'd0, tie_exp[k]});
      check("tie_i_resp", {63'd0, i_resp}, {63'd0, ~tie_exp[k]});
      tick();
      mem_resp = 1'b0;
      #1;
      check("tie_idle_gap", {63'd0, mem_read}, 64'd0);
    end
    i_read = 1'b0; d_read = 1'b0;

    // Reset during SERVE_D
    tick();
    d_read = 1'b1; d_addr = 32'h300;
    tick();
    check("r_serve_d", {63'd0, mem_read}, 64'd1);
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h77;
    #1;
    check("r_mem_read", {63'd0, mem_read}, 64'd0);
    check("r_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("r_d_resp", {63'd0, d_resp}, 64'd0);
    check("r_d_rdata", {32'd0, d_rdata}, 64'd0);
    tick();
    rst = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    i_read = 1'b1; i_addr = 32'h400;
    tick();
    check("r_post_fetch_addr", {32'd0, mem_addr}, 64'h400);
    check("r_post_fetch_read", {63'd0, mem_read}, 64'd1);
    mem_resp = 1'b1; mem_rdata = 32'h55;
    #1;
    check("r_post_i_rdata", {32'd0, i_rdata}, 64'h55);
    tick();
    i_read = 1'b0; mem_resp = 1'b0;

    // Stray mem_resp in IDLE
    mem_resp = 1'b1; mem_rdata = 32'h99;
    #1;
    check("s_no_resp", {62'd0, i_resp, d_resp}, 64'd0);
    tick();
    check("s_stay_idle", {62'd0, mem_read, mem_write}, 64'd0);
    mem_resp = 1'b0;

    // Read+write together is a write; dropping the request mid-flight
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h500; d_wdata = 32'hA5A5A5A5; d_be = 4'hC;
    tick();
    check("rw_mem_write", {63'd0, mem_write}, 64'd1);
    check("rw_mem_read", {63'd0, mem_read}, 64'd0);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    check("drop_still_busy", {63'd0, mem_write}, 64'd1);
    mem_resp = 1'b1; mem_rdata = 32'h0;
    #1;
    check("drop_d_resp", {63'd0, d_resp}, 64'd1);
    tick();
    mem_resp = 1'b0;
    #1;
    check("drop_idle", {62'd0, mem_read, mem_write}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
